i2c_bus_monitor: RTL and testbench

I2C_BUS_MONITOR -- requirements
Module: i2c_bus_monitor

---
 rtl/i2c_bus_monitor.sv | 270 +++++++++++++++++++++++++++
 tb/tb_i2c_bus_monitor.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_monitor.sv
// ---------------------------------------------------------------------------
// i2c_bus_monitor
//
// Passive I2C bus observer. The raw SCL/SDA pins are synchronized every clk,
// then sampled on clk cycles where `capture` is high. Consecutive samples are
// compared to find START, STOP and data-bit (SCL rising) events, and the data
// bits are assembled into bytes of 8 data bits plus the ACK/NAK bit.
//
// Optional build macro: I2C_MON_FILTER_EN
//   Defined   -> each line passes through a debounce filter that only accepts
//                a new level after FILTER_LEN consecutive differing samples.
//   Undefined -> detection uses the raw synchronized samples.
//
// Ports
//   clk          in   single clock, all logic on posedge
//   reset        in   synchronous, active-high
//   capture      in   one-clk sample strobe
//   scl_in       in   raw asynchronous SCL
//   sda_in       in   raw asynchronous SDA
//   byte_data    out  [7:0] last received byte (MSB first on the wire)
//   byte_ack     out  ninth bit of that byte (0 = ACK, 1 = NAK)
//   byte_valid   out  one-clk pulse, byte_data/byte_ack/byte_first valid
//   byte_first   out  byte is the first after a START / repeated START
//   bus_start    out  one-clk pulse on START or repeated START
//   bus_stop     out  one-clk pulse on STOP
//   bus_busy     out  level, high from START until STOP (mirrors FSM state)
//   frame_error  out  one-clk pulse, START/STOP arrived mid-byte
// ---------------------------------------------------------------------------
module i2c_bus_monitor #(
  parameter int FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       capture,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic [7:0] byte_data,
  output logic       byte_ack,
  output logic       byte_valid,
  output logic       byte_first,
  output logic       bus_start,
  output logic       bus_stop,
  output logic       bus_busy,
  output logic       frame_error
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // ---------------------------------------------------------------- sync
  // Synchronizers load 1 on reset so that an idle bus looks idle at once.
  logic [1:0] scl_sync_q, sda_sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_in};
      sda_sync_q <= {sda_sync_q[0], sda_in};
    end
  end

  // Line values used for edge detection on a capture cycle.
  logic cur_scl, cur_sda;

`ifdef I2C_MON_FILTER_EN
  // ---------------------------------------------------------------- filter
  // A filtered level flips on the FILTER_LEN-th consecutive differing sample;
  // the flipped value is used in that same capture cycle, so the added delay
  // is FILTER_LEN-1 capture periods.
  localparam int FCW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

  logic           scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;
  logic [FCW-1:0] scl_fcnt_q, scl_fcnt_d, sda_fcnt_q, sda_fcnt_d;

  always_comb begin
    scl_filt_d = scl_filt_q;
    scl_fcnt_d = scl_fcnt_q;
    sda_filt_d = sda_filt_q;
    sda_fcnt_d = sda_fcnt_q;
    if (capture) begin
      if (scl_sync_q[1] == scl_filt_q) begin
        scl_fcnt_d = '0;
      end else if (scl_fcnt_q == FCW'(FILTER_LEN - 1)) begin
        scl_filt_d = scl_sync_q[1];
        scl_fcnt_d = '0;
      end else begin
        scl_fcnt_d = scl_fcnt_q + 1'b1;
      end
      if (sda_sync_q[1] == sda_filt_q) begin
        sda_fcnt_d = '0;
      end else if (sda_fcnt_q == FCW'(FILTER_LEN - 1)) begin
        sda_filt_d = sda_sync_q[1];
        sda_fcnt_d = '0;
      end else begin
        sda_fcnt_d = sda_fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
      scl_fcnt_q <= '0;
      sda_fcnt_q <= '0;
    end else begin
      scl_filt_q <= scl_filt_d;
      sda_filt_q <= sda_filt_d;
      scl_fcnt_q <= scl_fcnt_d;
      sda_fcnt_q <= sda_fcnt_d;
    end
  end

  assign cur_scl = scl_filt_d;
  assign cur_sda = sda_filt_d;
`else
  assign cur_scl = scl_sync_q[1];
  assign cur_sda = sda_sync_q[1];
`endif

  // ---------------------------------------------------------------- edges
  logic prev_scl_q, prev_sda_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_scl_q <= 1'b1;
      prev_sda_q <= 1'b1;
    end else if (capture) begin
      prev_scl_q <= cur_scl;
      prev_sda_q <= cur_sda;
    end
  end

  logic scl_rise, scl_low, start_ev, stop_ev;

  // START/STOP both need SCL high in both samples, so they can never
  // coincide with an SCL rise: the rise wins by construction.
  assign scl_rise = capture & ~prev_scl_q & cur_scl;
  assign scl_low  = capture & ~cur_scl;
  assign start_ev = capture & prev_scl_q & cur_scl &  prev_sda_q & ~cur_sda;
  assign stop_ev  = capture & prev_scl_q & cur_scl & ~prev_sda_q &  cur_sda;

  // ---------------------------------------------------------------- FSM
  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       first_q, first_d;
  // SCL has risen on a counted bit and stayed high since. A START/STOP
  // always needs SCL raised with SDA at its pre-condition level, so that
  // last rise is the condition's setup, not a byte bit.
  logic       pending_q, pending_d;
  logic       partial;

  logic [7:0] byte_data_q, byte_data_d;
  logic       byte_ack_q, byte_ack_d, byte_first_q, byte_first_d;
  logic       byte_valid_q, byte_valid_d, bus_start_q, bus_start_d;
  logic       bus_stop_q, bus_stop_d, bus_busy_q, bus_busy_d;
  logic       frame_error_q, frame_error_d;

  assign partial = (bit_cnt_q != 4'd0) && !(pending_q && (bit_cnt_q == 4'd1));

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    first_d       = first_q;
    pending_d     = pending_q;
    byte_data_d   = byte_data_q;
    byte_ack_d    = byte_ack_q;
    byte_first_d  = byte_first_q;
    byte_valid_d  = 1'b0;
    bus_start_d   = 1'b0;
    bus_stop_d    = 1'b0;
    frame_error_d = 1'b0;

    if (scl_low) pending_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_ev) begin
          state_d     = ST_ACTIVE;
          bit_cnt_d   = 4'd0;
          shift_d     = 8'h00;
          first_d     = 1'b1;
          pending_d   = 1'b0;
          bus_start_d = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (scl_rise) begin
          pending_d = 1'b1;
          if (bit_cnt_q == 4'd8) begin
            byte_valid_d = 1'b1;
            byte_data_d  = shift_q;
            byte_ack_d   = cur_sda;
            byte_first_d = first_q;
            bit_cnt_d    = 4'd0;
            first_d      = 1'b0;
          end else begin
            shift_d   = {shift_q[6:0], cur_sda};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (start_ev) begin
          bus_start_d   = 1'b1;
          frame_error_d = partial;
          bit_cnt_d     = 4'd0;
          shift_d       = 8'h00;
          first_d       = 1'b1;
          pending_d     = 1'b0;
        end else if (stop_ev) begin
          bus_stop_d    = 1'b1;
          frame_error_d = partial;
          state_d       = ST_IDLE;
          bit_cnt_d     = 4'd0;
          shift_d       = 8'h00;
          pending_d     = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    bus_busy_d = (state_d == ST_ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= 4'd0;
      shift_q       <= 8'h00;
      first_q       <= 1'b0;
      pending_q     <= 1'b0;
      byte_data_q   <= 8'h00;
      byte_ack_q    <= 1'b0;
      byte_first_q  <= 1'b0;
      byte_valid_q  <= 1'b0;
      bus_start_q   <= 1'b0;
      bus_stop_q    <= 1'b0;
      bus_busy_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      first_q       <= first_d;
      pending_q     <= pending_d;
      byte_data_q   <= byte_data_d;
      byte_ack_q    <= byte_ack_d;
      byte_first_q  <= byte_first_d;
      byte_valid_q  <= byte_valid_d;
      bus_start_q   <= bus_start_d;
      bus_stop_q    <= bus_stop_d;
      bus_busy_q    <= bus_busy_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign byte_data   = byte_data_q;
  assign byte_ack    = byte_ack_q;
  assign byte_first  = byte_first_q;
  assign byte_valid  = byte_valid_q;
  assign bus_start   = bus_start_q;
  assign bus_stop    = bus_stop_q;
  assign bus_busy    = bus_busy_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Bench for i2c_bus_monitor: directed vector table, reset / filter
// sequences, then random wire traffic against a bit-queue reference model.
module tb_i2c_bus_monitor;

  localparam int FLEN = 3;
`ifdef I2C_MON_FILTER_EN
  localparam int HOLD = FLEN;
`else
  localparam int HOLD = 1;
`endif

  localparam int OP_START = 0;
  localparam int OP_STOP  = 1;
  localparam int OP_BYTE  = 2;
  localparam int OP_BITS  = 3;

  // ------------------------------------------------------------ clock/reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic capture = 1'b0;
  logic scl_in = 1'b1;
  logic sda_in = 1'b1;
  logic [7:0] byte_data;
  logic byte_ack, byte_valid, byte_first, bus_start, bus_stop, bus_busy, frame_error;

  always #5 clk = ~clk;

  i2c_bus_monitor #(.FILTER_LEN(FLEN)) dut (
    .clk(clk), .reset(reset), .capture(capture), .scl_in(scl_in), .sda_in(sda_in),
    .byte_data(byte_data), .byte_ack(byte_ack), .byte_valid(byte_valid),
    .byte_first(byte_first), .bus_start(bus_start), .bus_stop(bus_stop),
    .bus_busy(bus_busy), .frame_error(frame_error)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // ------------------------------------------------------------ monitor
  // Event word: [11:10] kind (0 start, 1 stop, 2 frame error, 3 byte),
  // [9] first, [8] ack, [7:0] data.
  logic [11:0] exp_q[$];
  logic [11:0] got_q[$];
  int n_start, n_stop, n_ferr, n_valid, n_sf;
  logic [7:0] l_data;
  logic l_ack, l_first;

  always @(negedge clk) begin
    if (bus_start) begin n_start++; got_q.push_back(12'h000); end
    if (bus_stop) begin n_stop++; got_q.push_back(12'h400); end
    if (frame_error) begin n_ferr++; got_q.push_back(12'h800); end
    if (bus_stop && frame_error) n_sf++;
    if (byte_valid) begin
      n_valid++;
      l_data = byte_data; l_ack = byte_ack; l_first = byte_first;
      got_q.push_back({2'd3, byte_first, byte_ack, byte_data});
    end
  end

  task automatic clear_counts();
    n_start = 0; n_stop = 0; n_ferr = 0; n_valid = 0; n_sf = 0;
  endtask

  // ------------------------------------------------------------ model
  // Protocol-level view: a queue of bits since the last byte boundary.
  // The SCL rise that sets up a START/STOP is not part of any byte.
  bit mq[$];
  bit m_active = 1'b0, m_first = 1'b0, m_after_rise = 1'b0;

  function automatic void m_push(input logic [1:0] k, input logic f, input logic a,
                                 input logic [7:0] d);
    exp_q.push_back({k, f, a, d});
  endfunction

  function automatic bit m_partial();
    return mq.size() > (m_after_rise ? 1 : 0);
  endfunction

  function automatic void m_rise(input bit b);
    logic [7:0] d;
    if (!m_active) return;
    mq.push_back(b);
    m_after_rise = 1'b1;
    if (mq.size() == 9) begin
      d = 8'h00;
      for (int i = 0; i < 8; i++) d = {d[6:0], mq[i]};
      m_push(2'd3, m_first, mq[8], d);
      m_first = 1'b0;
      mq.delete();
    end
  endfunction

  function automatic void m_start();
    m_push(2'd0, 1'b0, 1'b0, 8'h00);
    if (m_active && m_partial()) m_push(2'd2, 1'b0, 1'b0, 8'h00);
    m_active = 1'b1; m_first = 1'b1; m_after_rise = 1'b0;
    mq.delete();
  endfunction

  function automatic void m_stop();
    if (!m_active) return;
    m_push(2'd1, 1'b0, 1'b0, 8'h00);
    if (m_partial()) m_push(2'd2, 1'b0, 1'b0, 8'h00);
    m_active = 1'b0; m_after_rise = 1'b0;
    mq.delete();
  endfunction

  // ------------------------------------------------------------ drivers
  logic cur_scl = 1'b1, cur_sda = 1'b1;

  task automatic pulse_caps(input int n);
    repeat (n) begin
      @(negedge clk) capture = 1'b1;
      @(negedge clk) capture = 1'b0;
    end
  endtask

  task automatic set_lines(input logic s, input logic d);
    if (!cur_scl && s) m_rise(d);
    else if (cur_scl && !s) m_after_rise = 1'b0;
    else if (cur_scl && s && cur_sda && !d) m_start();
    else if (cur_scl && s && !cur_sda && d) m_stop();
    cur_scl = s; cur_sda = d;
    scl_in = s; sda_in = d;
    repeat (3) @(negedge clk);
    pulse_caps(HOLD);
    repeat (2) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    if (cur_scl) set_lines(1'b0, cur_sda);
    if (cur_sda != b) set_lines(1'b0, b);
    set_lines(1'b1, b);
  endtask

  task automatic drive_start();
    if (cur_scl && cur_sda) set_lines(1'b1, 1'b0);
    else begin
      if (cur_scl) set_lines(1'b0, cur_sda);
      if (!cur_sda) set_lines(1'b0, 1'b1);
      set_lines(1'b1, 1'b1);
      set_lines(1'b1, 1'b0);
    end
  endtask

  task automatic drive_stop();
    if (cur_scl && !cur_sda) set_lines(1'b1, 1'b1);
    else begin
      if (cur_scl) set_lines(1'b0, cur_sda);
      if (cur_sda) set_lines(1'b0, 1'b0);
      set_lines(1'b1, 1'b0);
      set_lines(1'b1, 1'b1);
    end
  endtask

  task automatic drive_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) drive_bit(v[7-i]);
  endtask

  task automatic drive_byte(input logic [7:0] v, input logic ack);
    drive_bits(v, 8);
    drive_bit(ack);
  endtask

  // ------------------------------------------------------------ vectors
  typedef struct {
    int op; logic [7:0] val; int n;
    int es, ep, ef, ev;
    logic [7:0] ed; logic ea; logic efst; logic eb;
  } vec_t;

  function automatic vec_t mkv(input int op, input logic [7:0] val, input int n,
                               input int es, input int ep, input int ef, input int ev,
                               input logic [7:0] ed, input logic ea, input logic efst,
                               input logic eb);
    vec_t r;
    r.op = op; r.val = val; r.n = n; r.es = es; r.ep = ep; r.ef = ef; r.ev = ev;
    r.ed = ed; r.ea = ea; r.efst = efst; r.eb = eb;
    return r;
  endfunction

  vec_t tbl[23];
  logic [7:0] hold_data;
  logic hold_ack, hold_first;

  initial begin
    //                op        val    n  st sp fe bv data   ack first busy
    tbl[0]  = mkv(OP_START, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 0, 1);
    tbl[1]  = mkv(OP_BYTE,  8'hA5, 0, 0, 0, 0, 1, 8'hA5, 0, 1, 1);
    tbl[2]  = mkv(OP_STOP,  8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0);
    tbl[3]  = mkv(OP_START, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 0, 1);
    tbl[4]  = mkv(OP_BYTE,  8'h3C, 1, 0, 0, 0, 1, 8'h3C, 1, 1, 1);
    tbl[5]  = mkv(OP_BYTE,  8'h7E, 0, 0, 0, 0, 1, 8'h7E, 0, 0, 1);
    tbl[6]  = mkv(OP_STOP,  8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0);
    tbl[7]  = mkv(OP_START, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 0, 1);
    tbl[8]  = mkv(OP_BYTE,  8'h90, 0, 0, 0, 0, 1, 8'h90, 0, 1, 1);
    tbl[9]  = mkv(OP_START, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 0, 1);
    tbl[10] = mkv(OP_BYTE,  8'h91, 0, 0, 0, 0, 1, 8'h91, 0, 1, 1);
    tbl[11] = mkv(OP_BYTE,  8'h55, 1, 0, 0, 0, 1, 8'h55, 1, 0, 1);
    tbl[12] = mkv(OP_STOP,  8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0);
    tbl[13] = mkv(OP_START, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 0, 1);
    tbl[14] = mkv(OP_BITS,  8'hA0, 4, 0, 0, 0, 0, 8'h00, 0, 0, 1);
    tbl[15] = mkv(OP_STOP,  8'h00, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0);
    tbl[16] = mkv(OP_STOP,  8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    tbl[17] = mkv(OP_BITS,  8'hE0, 3, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    tbl[18] = mkv(OP_START, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 0, 1);
    tbl[19] = mkv(OP_BITS,  8'hC8, 5, 0, 0, 0, 0, 8'h00, 0, 0, 1);
    tbl[20] = mkv(OP_START, 8'h00, 0, 1, 0, 1, 0, 8'h00, 0, 0, 1);
    tbl[21] = mkv(OP_BYTE,  8'h01, 0, 0, 0, 0, 1, 8'h01, 0, 1, 1);
    tbl[22] = mkv(OP_STOP,  8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0);
  end

  // ------------------------------------------------------------ test
  initial begin
    int n_ops, op, cnt;
    clear_counts();
    repeat (4) @(negedge clk);
    check("reset_data", byte_data, 8'h00);
    check("reset_flags", {byte_ack, byte_first, byte_valid, bus_start, bus_stop,
                          bus_busy, frame_error}, 7'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    pulse_caps(2);
    check("post_reset_flags", {byte_valid, bus_start, bus_stop, bus_busy, frame_error}, 5'd0);

    // Directed table.
    hold_data = 8'h00; hold_ack = 1'b0; hold_first = 1'b0;
    for (int i = 0; i < 23; i++) begin
      clear_counts();
      case (tbl[i].op)
        OP_START: drive_start();
        OP_STOP:  drive_stop();
        OP_BYTE:  drive_byte(tbl[i].val, tbl[i].n[0]);
        default:  drive_bits(tbl[i].val, tbl[i].n);
      endcase
      repeat (2) @(negedge clk);
      check($sformatf("v%0d_start", i), n_start, tbl[i].es);
      check($sformatf("v%0d_stop", i), n_stop, tbl[i].ep);
      check($sformatf("v%0d_ferr", i), n_ferr, tbl[i].ef);
      check($sformatf("v%0d_valid", i), n_valid, tbl[i].ev);
      check($sformatf("v%0d_busy", i), bus_busy, tbl[i].eb);
      if (tbl[i].ep != 0 && tbl[i].ef != 0) check($sformatf("v%0d_stop_ferr_same", i), n_sf, 1);
      if (tbl[i].ev != 0) begin
        hold_data = tbl[i].ed; hold_ack = tbl[i].ea; hold_first = tbl[i].efst;
      end
      // Byte fields must track the last byte and hold between bytes.
      check($sformatf("v%0d_byte", i), {byte_first, byte_ack, byte_data},
            {hold_first, hold_ack, hold_data});
    end

    // Reset in the middle of a byte.
    drive_start();
    drive_bits(8'hF8, 5);
    @(negedge clk);
    reset = 1'b1;
    scl_in = 1'b1; sda_in = 1'b1; cur_scl = 1'b1; cur_sda = 1'b1;
    m_active = 1'b0; m_after_rise = 1'b0; mq.delete();
    repeat (3) @(negedge clk);
    check("midreset_data", byte_data, 8'h00);
    check("midreset_flags", {byte_ack, byte_first, byte_valid, bus_start, bus_stop,
                             bus_busy, frame_error}, 7'd0);
    reset = 1'b0;
    clear_counts();
    repeat (3) @(negedge clk);
    pulse_caps(4);
    repeat (2) @(negedge clk);
    check("after_reset_start", n_start, 0);
    check("after_reset_ferr", n_ferr, 0);
    check("after_reset_busy", bus_busy, 0);
    clear_counts();
    drive_start();
    drive_byte(8'h5A, 1'b0);
    check("after_reset_byte", {n_valid[3:0], l_first, l_ack, l_data}, {4'd1, 1'b1, 1'b0, 8'h5A});
    drive_stop();

    // Short SDA glitch while SCL is high.
    clear_counts();
    sda_in = 1'b0;
    repeat (3) @(negedge clk);
    pulse_caps(1);
    sda_in = 1'b1;
    repeat (3) @(negedge clk);
    pulse_caps(HOLD + 1);
    repeat (2) @(negedge clk);
`ifdef I2C_MON_FILTER_EN
    check("glitch_start", n_start, 0);
    check("glitch_stop", n_stop, 0);
    set_lines(1'b1, 1'b0);
    check("filtered_start", n_start, 1);
    check("filtered_busy", bus_busy, 1);
    set_lines(1'b1, 1'b1);
    check("filtered_stop", n_stop, 1);
`else
    check("glitch_start", n_start, 1);
    check("glitch_stop", n_stop, 1);
    check("glitch_busy", bus_busy, 0);
`endif

    // Random traffic against the reference model.
    repeat (3) @(negedge clk);
    exp_q.delete(); got_q.delete();
    n_ops = 45;
    for (int k = 0; k < n_ops; k++) begin
      op = $urandom_range(0, 9);
      if (op < 3) drive_start();
      else if (op < 5) drive_stop();
      else if (op < 8) drive_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      else drive_bits(8'($urandom_range(0, 255)), $urandom_range(1, 8));
    end
    drive_stop();
    repeat (3) @(negedge clk);
    check("rand_count", got_q.size(), exp_q.size());
    cnt = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < cnt; i++) check($sformatf("rand_ev%0d", i), got_q[i], exp_q[i]);
    check("rand_end_busy", bus_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
